// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner sequencing for a shared tri-state bus, with a dead turnaround cycle between owners.
// Define TRI_BUS_TIMEOUT_EN to add the hold counter and HOLD_MAX preemption.
module tri_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         grant,
   output logic                    owner_valid,
   output logic [$clog2(NREQ)-1:0] owner_id,
   output logic                    timeout
);
   localparam int IW = $clog2(NREQ);
   localparam logic [1:0] S_IDLE = 2'd0, S_OWN = 2'd1, S_TURN = 2'd2;
   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IW-1:0]   owner_q, owner_d, last_q, last_d;
   logic            timeout_q, timeout_d;
   logic [IW-1:0]   win, idx;
   logic            found, preempt;
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last_q) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
`ifdef TRI_BUS_TIMEOUT_EN
   localparam int HW = $clog2(HOLD_MAX + 1);
   logic [HW-1:0] hold_q, hold_d;
   assign preempt = (hold_q == HW'(HOLD_MAX)) && |(req & ~grant_q);
   always_comb
      hold_d = state_q != S_OWN ? HW'(found && state_q == S_IDLE)
             : hold_q == HW'(HOLD_MAX) ? hold_q : hold_q + HW'(1);
   always_ff @(posedge clk)
      hold_q <= !reset_n ? '0 : hold_d;
`else
   assign preempt = 1'b0;
`endif
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      last_d    = last_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: if (found) begin
            state_d = S_OWN;
            grant_d = NREQ'(1) << win;
            owner_d = win;
            last_d  = win;
         end
         S_OWN: if (!req[owner_q] || preempt) begin
            state_d   = S_TURN;
            grant_d   = '0;
            owner_d   = '0;
            // a normal release wins over a coincident preemption
            timeout_d = req[owner_q];
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         last_q    <= IW'(NREQ - 1);
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end
   assign grant       = grant_q;
   assign owner_valid = |grant_q;
   assign owner_id    = owner_q;
   assign timeout     = timeout_q;
endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Round-robin arbiter and sequencer for a shared N-bit tri-state bus built from per-requester `tri_state_buffer_nbit` instances. It grants the bus to one requester at a time and drives the buffer enables as a registered one-hot vector. It inserts a guaranteed one-cycle dead (all-enables-low) turnaround between owners so no two drivers ever overlap. It optionally preempts an owner that exceeds a hold limit while others wait.

## Interface
- `NREQ`, default 4: number of requesters/drivers; must be ≥ 2.
- `HOLD_MAX`, default 16: maximum consecutive owned cycles before preemption. Used only with the timeout feature; must be ≥ 1.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `req` input, NREQ bits: level request per requester; held high for as long as the bus is wanted.
- `grant` output, NREQ bits: registered one-hot (or zero) vector. `grant[i]` connects directly to requester i's tri-state buffer `en`.
- `owner_valid` output, 1 bit: high while any `grant` bit is high.
- `owner_id` output, $clog2(NREQ) bits: index of the current owner; 0 when `owner_valid` is low.
- `timeout` output, 1 bit: one-cycle pulse coinciding with a preemptive release.

## Operation
- FSM states: IDLE, OWN, TURN.
- IDLE: `grant` = 0. If any `req` bit is high, select a winner and go to OWN.
- Winner selection: round-robin search starting at `(last + 1) mod NREQ`, where `last` is the most recent owner. The first requester with `req` high wins. `last` is updated to the winner on entry to OWN.
- OWN: `grant[winner]` = 1. The hold counter increments each cycle in OWN, starting at 1 in the first OWN cycle and saturating at HOLD_MAX.
- OWN → TURN when `req[owner]` is sampled low (normal release).
- OWN → TURN (preemption, timeout feature only) when the counter equals HOLD_MAX and any other `req` bit is high.
- With no competitor pending, the owner keeps the bus past HOLD_MAX and the counter stays saturated.
- TURN: `grant` = 0 for exactly one cycle, then go to IDLE.
- The next grant is evaluated in IDLE. This gives at least one dead cycle between owners and two cycles from a release sample to the next grant.
- Simultaneous normal release and preemption condition in the same cycle: treated as a normal release; `timeout` stays low.
- A preempted owner whose `req` is still high re-enters arbitration with the lowest priority, because `last` equals its index.
- A requester that drops `req` before being granted is simply skipped; no latching of requests.
- Invariant: `grant` is never multi-hot on any cycle, including the cycle after reset.

## Timing
- Reset (`reset_n` low at a rising edge, any state, including mid-ownership):
  - next cycle: `grant` = 0, `owner_valid` = 0, `owner_id` = 0, `timeout` = 0;
  - state = IDLE, hold counter = 0, `last` = NREQ-1, so requester 0 has first priority.
- Grant latency: `req` sampled high in IDLE at edge k → `grant` high after edge k (visible during cycle k+1).
- Release latency: `req[owner]` sampled low at edge m → `grant` = 0 after edge m (TURN). The earliest next grant is visible after edge m+2.
- Preemption: after HOLD_MAX cycles of `grant` high with a competitor pending, `grant` drops and `timeout` pulses high for one cycle (the TURN cycle).
- All outputs come straight from registers; no combinational path from `req` to `grant`.
- Back-to-back ownership by the same requester also passes through TURN (re-request after release costs a dead cycle).

## Configuration
- Macro `TRI_BUS_TIMEOUT_EN`.
- Defined: hold counter and preemption logic are present; `timeout` behaves as above.
- Undefined: no hold counter. The owner keeps the bus until it drops `req`, `timeout` is tied to 0, and `HOLD_MAX` is ignored.

## Test plan
- Reset then `req`=4'b0001 → `grant`=0001 and `owner_id`=0 one cycle later. Drop `req[0]` → one cycle `grant`=0000, then IDLE.
- `req`=4'b1111 held, each owner releasing after 2 cycles and re-requesting → grant order 0,1,2,3,0. Every handoff is separated by exactly one `grant`=0000 cycle; `grant` is never multi-hot.
- Owner 2 holds with `req`=4'b0110, feature on, HOLD_MAX=16 → after 16 owned cycles `grant` drops, `timeout` pulses once, and the next grant goes to 1 (search wraps 3,0,1). The same stimulus with the macro undefined → owner 2 keeps the bus indefinitely and `timeout` stays 0.
- Only owner 3 requesting for 40 cycles, feature on → no preemption, `timeout` stays 0. `req[0]` then rises → preemption on the next cycle because the counter is saturated.
- `reset_n` pulsed low during OWN with owner 1 → `grant`=0 and `owner_valid`=0 the next cycle. With `req`=4'b0011 afterwards, requester 0 is granted first.
- Release and HOLD_MAX reached on the same cycle with a competitor pending → TURN entered and `timeout` stays 0.
